// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
//
// Multi-cycle control unit for the 16-bit CPU datapath. Each instruction
// passes through FETCH / DECODE / EXEC / MEM / WB as its opcode requires.
// Every datapath write enable and mux select is decoded from the current
// state and the IR opcode (Moore style). Opcode F parks the unit in HALT.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset (0 = in reset)
//   en           global enable; 0 freezes state and masks all write enables
//   opcode       IR[15:12], stable from DECODE through WB
//   zero         ALU zero flag, used by BEQ in EXEC
//   ir_we        load IR from instruction memory
//   pc_we        load PC
//   pc_src       0 = PC+1, 1 = PC+sext(imm) (branch), 2 = IR[7:0] (jump)
//   alu_src_imm  ALU B operand: 0 = rt, 1 = sext(imm6)
//   alu_op       0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT
//   dmem_we      data memory write
//   wb_sel       register write data: 0 = ALU, 1 = data memory
//   rf_we        register file write
//   retire       pulse on the last cycle of each completed instruction
//   halted       high while in HALT
//   state        current state code (debug)
//   illegal      (CTRL_ILLEGAL_TRAP_EN only) sticky undefined-opcode flag
//
// Build option:
//   CTRL_ILLEGAL_TRAP_EN - undefined opcodes trap to HALT and set `illegal`
//                          instead of executing as a NOP.
// ---------------------------------------------------------------------------
module cpu_control_fsm #(
  parameter int OPW    = 4,
  parameter int ALUOPW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              alu_src_imm,
  output logic [ALUOPW-1:0] alu_op,
  output logic              dmem_we,
  output logic              wb_sel,
  output logic              rf_we,
  output logic              retire,
  output logic              halted,
  output logic [2:0]        state
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic              illegal
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [OPW-1:0] OP_ADDI = 4'h0;
  localparam logic [OPW-1:0] OP_LW   = 4'h1;
  localparam logic [OPW-1:0] OP_SW   = 4'h2;
  localparam logic [OPW-1:0] OP_BEQ  = 4'h3;
  localparam logic [OPW-1:0] OP_JMP  = 4'h4;
  localparam logic [OPW-1:0] OP_HALT = 4'hF;

  localparam logic [ALUOPW-1:0] ALU_ADD = 3'd0;
  localparam logic [ALUOPW-1:0] ALU_SUB = 3'd1;

  state_e state_q, state_d, next_state;

  // Un-gated enables; en masks them at the output.
  logic ir_we_c, pc_we_c, dmem_we_c, rf_we_c, retire_c, trap_c;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    next_state  = state_q;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    dmem_we_c   = 1'b0;
    rf_we_c     = 1'b0;
    retire_c    = 1'b0;
    trap_c      = 1'b0;
    pc_src      = 2'd0;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    wb_sel      = 1'b0;
    halted      = 1'b0;

    case (state_q)
      FETCH: begin
        ir_we_c    = 1'b1;
        pc_we_c    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_JMP: begin
            pc_we_c    = 1'b1;
            pc_src     = 2'd2;
            retire_c   = 1'b1;
            next_state = FETCH;
          end
          OP_HALT: begin
            retire_c   = 1'b1;
            next_state = HALT;
          end
          4'h5, 4'h6, 4'h7, 4'hE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            trap_c     = 1'b1;
            next_state = HALT;
`else
            retire_c   = 1'b1;
            next_state = FETCH;
`endif
          end
          default: next_state = EXEC;
        endcase
      end
      EXEC: begin
        if (opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW) begin
          alu_src_imm = 1'b1;
          next_state  = (opcode == OP_ADDI) ? WB : MEM;
        end else if (opcode == OP_BEQ) begin
          alu_op     = ALU_SUB;
          pc_we_c    = zero;
          pc_src     = 2'd1;
          retire_c   = 1'b1;
          next_state = FETCH;
        end else begin
          // R-type opcodes 8..D map onto ALU ops 0..5 by their low bits.
          alu_op     = ALUOPW'(opcode[2:0]);
          next_state = WB;
        end
      end
      MEM: begin
        if (opcode == OP_SW) begin
          dmem_we_c  = 1'b1;
          retire_c   = 1'b1;
          next_state = FETCH;
        end else begin
          next_state = WB;
        end
      end
      WB: begin
        rf_we_c    = 1'b1;
        wb_sel     = (opcode == OP_LW);
        retire_c   = 1'b1;
        next_state = FETCH;
      end
      HALT: begin
        halted     = 1'b1;
        next_state = HALT;
      end
      default: next_state = FETCH;
    endcase
  end

  assign state_d = en ? next_state : state_q;

  assign ir_we   = en & ir_we_c;
  assign pc_we   = en & pc_we_c;
  assign dmem_we = en & dmem_we_c;
  assign rf_we   = en & rf_we_c;
  assign retire  = en & retire_c;
  assign state   = state_q;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of block ordering.
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (en & trap_c);
  assign illegal   = illegal_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
`else
  logic unused_trap;
  assign unused_trap = trap_c;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_control_fsm
//
// Self-checking bench for cpu_control_fsm. A behavioural model tracks which
// instruction is in flight and how many cycles of it have elapsed; the
// expected control word for each cycle is derived from the instruction's
// cycle budget and per-phase rules. A compare process checks every clocked
// cycle; directed sequences pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_cpu_control_fsm;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;

  logic       ir_we, pc_we, alu_src_imm, dmem_we, wb_sel, rf_we, retire, halted;
  logic [1:0] pc_src;
  logic [2:0] alu_op, state;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  cpu_control_fsm #(.OPW(4), .ALUOPW(3)) dut (
    .clk(clk), .reset(reset), .en(en), .opcode(opcode), .zero(zero),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_imm(alu_src_imm),
    .alu_op(alu_op), .dmem_we(dmem_we), .wb_sel(wb_sel), .rf_we(rf_we),
    .retire(retire), .halted(halted), .state(state)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       alu_src_imm;
    logic [2:0] alu_op;
    logic       dmem_we;
    logic       wb_sel;
    logic       rf_we;
    logic       retire;
    logic       halted;
    logic [2:0] state;
  } ctl_t;

  ctl_t act, snap;
  assign act = {ir_we, pc_we, pc_src, alu_src_imm, alu_op, dmem_we, wb_sel,
                rf_we, retire, halted, state};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_k = 0;        // cycles of the current instruction already done
  logic [3:0] m_op = 4'h0;    // opcode captured when FETCH completes
  bit         m_halted = 1'b0;
  bit         m_illegal = 1'b0;

  function automatic bit is_undef(input logic [3:0] op);
    return op inside {4'h5, 4'h6, 4'h7, 4'hE};
  endfunction

  // Total cycles an instruction occupies, FETCH included.
  function automatic int cpi(input logic [3:0] op);
    if (op == 4'h4 || op == 4'hF || is_undef(op)) return 2;
    if (op == 4'h3) return 3;
    if (op == 4'h1) return 5;
    return 4;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_k       <= 0;
      m_halted  <= 1'b0;
      m_illegal <= 1'b0;
    end else if (en && !m_halted) begin
      if (m_k == 0) begin
        m_op <= opcode;
        m_k  <= 1;
      end else if (m_k + 1 >= cpi(m_op)) begin
        m_k <= 0;
        if (m_op == 4'hF) m_halted <= 1'b1;
        if (TRAP && is_undef(m_op)) begin
          m_halted  <= 1'b1;
          m_illegal <= 1'b1;
        end
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  function automatic ctl_t expect_ctl(input int k, input logic [3:0] op, input bit hlt,
                                      input logic en_v, input logic z);
    ctl_t e;
    int   phase;  // 0 fetch, 1 decode, 2 exec, 3 mem, 4 writeback
    e = '0;
    if (hlt) begin
      e.halted = 1'b1;
      e.state  = 3'd5;
      return e;
    end
    if (k <= 2)                                phase = k;
    else if (k == 3 && (op == 1 || op == 2))   phase = 3;
    else                                       phase = 4;
    e.state = 3'(phase);
    case (phase)
      0: begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
      1: begin
        if (op == 4'h4) begin e.pc_we = 1'b1; e.pc_src = 2'd2; e.retire = 1'b1; end
        else if (op == 4'hF) e.retire = 1'b1;
        else if (is_undef(op)) e.retire = !TRAP;
      end
      2: begin
        if (op <= 4'h2) e.alu_src_imm = 1'b1;
        else if (op == 4'h3) begin
          e.alu_op = 3'd1; e.pc_we = z; e.pc_src = 2'd1; e.retire = 1'b1;
        end else e.alu_op = 3'(op - 4'd8);
      end
      3: if (op == 4'h2) begin e.dmem_we = 1'b1; e.retire = 1'b1; end
      default: begin e.rf_we = 1'b1; e.wb_sel = (op == 4'h1); e.retire = 1'b1; end
    endcase
    if (!en_v) begin
      e.ir_we = 1'b0; e.pc_we = 1'b0; e.dmem_we = 1'b0; e.rf_we = 1'b0; e.retire = 1'b0;
    end
    return e;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("cycle", 32'(act), 32'(expect_ctl(m_k, m_op, m_halted, en, zero)));
`ifdef CTRL_ILLEGAL_TRAP_EN
      check("illegal_flag", 32'(illegal), 32'(m_illegal));
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] prog_q[$];

  task automatic get_op(output logic [3:0] op);
    if (prog_q.size() > 0) op = prog_q.pop_front();
    else begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h8;
    end
  endtask

  // Drive one cycle's inputs (called at posedge+1), sample at negedge,
  // return at the following posedge+1.
  task automatic run_cycle(input bit en_v, input bit zero_v);
    logic [3:0] op;
    if (m_k == 0 && !m_halted) begin
      get_op(op);
      opcode = op;
    end
    en   = en_v;
    zero = zero_v;
    @(negedge clk);
    snap = act;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    prog_q.delete();
    reset = 1'b0;
    en    = 1'b1;
    zero  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] mask, mask2;
    logic [14:0] seq;
    int          first_halt;

    // Reset state while reset is held.
    #2;
    check("reset_state", 32'({state, halted, rf_we, dmem_we}), 32'({3'd0, 1'b0, 1'b0, 1'b0}));

    // Program 0201, 0401, 8650, F000.
    do_reset();
    prog_q = '{4'h0, 4'h0, 4'h8, 4'hF};
    mask = '0;
    first_halt = 0;
    for (int c = 1; c <= 16; c++) begin
      run_cycle(1'b1, 1'b0);
      mask[c] = snap.retire;
      if (snap.halted && first_halt == 0) first_halt = c;
    end
    check("prog_retire_cycles", mask, 32'h0000_5110);
    check("prog_halt_cycle", 32'(first_halt), 32'd15);

    // ADD: state sequence 0,1,2,4,0; rf_we only in WB.
    do_reset();
    prog_q = '{4'h8};
    seq = '0;
    mask = '0;
    for (int c = 0; c < 5; c++) begin
      run_cycle(1'b1, 1'b0);
      seq = {seq[11:0], snap.state};
      mask[c] = snap.rf_we;
      if (c == 2) check("add_exec_alu", 32'({snap.alu_op, snap.alu_src_imm}), 32'({3'd0, 1'b0}));
    end
    check("add_state_seq", 32'(seq), 32'({3'd0, 3'd1, 3'd2, 3'd4, 3'd0}));
    check("add_rf_we", mask, 32'b01000);

    // LW: 5 cycles, wb_sel and rf_we in WB.
    do_reset();
    prog_q = '{4'h1};
    mask = '0;
    for (int c = 0; c < 6; c++) begin
      run_cycle(1'b1, 1'b0);
      mask[c] = snap.retire;
      if (c == 4) check("lw_wb", 32'({snap.wb_sel, snap.rf_we, snap.state}), 32'({1'b1, 1'b1, 3'd4}));
      if (c == 5) check("lw_back_to_fetch", 32'(snap.state), 32'd0);
    end
    check("lw_retire", mask, 32'b010000);

    // SW: dmem_we only in MEM, never rf_we.
    do_reset();
    prog_q = '{4'h2};
    mask = '0;
    mask2 = '0;
    for (int c = 0; c < 5; c++) begin
      run_cycle(1'b1, 1'b0);
      mask[c]  = snap.dmem_we;
      mask2[c] = snap.rf_we;
    end
    check("sw_dmem_we", mask, 32'b01000);
    check("sw_no_rf_we", mask2, 32'b0);

    // BEQ taken and not taken.
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      prog_q = '{4'h3};
      for (int c = 0; c < 4; c++) begin
        run_cycle(1'b1, z[0]);
        if (c == 2) check("beq_exec", 32'({snap.pc_we, snap.pc_src, snap.retire}), 32'({z[0], 2'd1, 1'b1}));
        if (c == 3) check("beq_done", 32'(snap.state), 32'd0);
      end
    end

    // Enable dropped for 3 cycles in EXEC.
    do_reset();
    prog_q = '{4'h8};
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      run_cycle(1'b0, 1'b0);
      check("en_freeze", 32'({snap.state, snap.ir_we, snap.pc_we, snap.dmem_we, snap.rf_we, snap.retire}),
            32'({3'd2, 5'b0}));
    end
    run_cycle(1'b1, 1'b0);
    check("en_resume_exec", 32'(snap.state), 32'd2);
    run_cycle(1'b1, 1'b0);
    check("en_resume_wb", 32'({snap.state, snap.rf_we}), 32'({3'd4, 1'b1}));

    // Asynchronous reset in WB.
    do_reset();
    prog_q = '{4'h8};
    repeat (3) run_cycle(1'b1, 1'b0);
    #1;
    check("wb_before_reset", 32'({state, rf_we}), 32'({3'd4, 1'b1}));
    reset = 1'b0;
    #1;
    check("async_reset", 32'({state, rf_we}), 32'({3'd0, 1'b0}));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Undefined opcode 6.
    prog_q = '{4'h6};
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b1, 1'b0);
    check("undef_decode", 32'({snap.pc_we, snap.dmem_we, snap.rf_we, snap.retire}),
          32'({3'b000, !TRAP}));
    run_cycle(1'b1, 1'b0);
    check("undef_next_state", 32'(snap.state), TRAP ? 32'd5 : 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("undef_illegal", 32'(illegal), 32'd1);
`endif

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
      else run_cycle($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit for the 16-bit CPU datapath (8-bit PC, 8 x 16-bit register file, instruction word opcode[15:12] rd[11:9] rs[8:6] rt[5:3]/imm[5:0]). It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives every datapath write enable and mux select. It parks in HALT on opcode F. The cpu_datapath top instantiates it alongside the ALU, register file and instruction and data memories.

Parameters:
OPW, 4, opcode width (fixed at 4; present for readability only)
ALUOPW, 3, alu_op output width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  global enable; 0 freezes the FSM and suppresses all write enables
opcode  input  4  IR[15:12]; stable from DECODE through WB because the IR is written only in FETCH
zero  input  1  ALU zero flag, valid in EXEC
ir_we  output  1  load IR from instruction memory
pc_we  output  1  load PC
pc_src  output  2  0 = PC+1, 1 = PC+sext(imm) (branch), 2 = IR[7:0] (jump)
alu_src_imm  output  1  ALU B operand: 0 = rt register, 1 = sext(imm6)
alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT
dmem_we  output  1  data memory write
wb_sel  output  1  register write data: 0 = ALU result, 1 = data memory
rf_we  output  1  register file write (rd); write to r0 is ignored by the regfile
retire  output  1  one-cycle pulse on the last cycle of each completed instruction
halted  output  1  high while in HALT
state  output  3  current state encoding, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Use a binary-encoded state register; codes 6 and 7 go to FETCH.
- Reset (reset=0, asynchronous): state=FETCH. All outputs are Moore-decoded from state and opcode and are 0 in FETCH except ir_we, pc_we, pc_src=0.
- en=0: state holds. ir_we, pc_we, dmem_we, rf_we and retire are forced 0. Mux selects still follow state.
- FETCH: ir_we=1, pc_we=1, pc_src=0. Next state DECODE.
- DECODE: register read.
  - opcode 4 (JMP): pc_we=1, pc_src=2, retire=1, then FETCH.
  - opcode F (HALT): retire=1, then HALT.
  - All other opcodes go to EXEC.
- EXEC:
  - alu_op mapping: opcode 0/1/2 (ADDI/LW/SW) -> ADD with alu_src_imm=1. Opcodes 8/9/A/B/C/D -> alu_op 0..5 with alu_src_imm=0.
  - opcode 3 (BEQ): alu_op=SUB, alu_src_imm=0; pc_we=zero, pc_src=1, retire=1, then FETCH.
  - LW/SW go to MEM. ADDI and R-type go to WB.
- MEM:
  - SW: dmem_we=1, retire=1, then FETCH.
  - LW: then WB. Data memory is read-only here; read latency is 1 cycle.
- WB: rf_we=1, wb_sel=1 for LW else 0, retire=1, then FETCH.
- HALT: all enables 0, halted=1. Stays until reset.
- Cycles per instruction: JMP 2, HALT 2 to reach HALT, BEQ 3, ADDI/R-type/SW 4, LW 5.
- Undefined opcodes (5, 6, 7, E): treated as NOP. Path is FETCH -> DECODE -> FETCH with retire=1 in DECODE, no writes (see optional feature).
- Reset asserted mid-instruction: any partial write is abandoned. Next cycle after release is FETCH at the PC the datapath reset to (0).

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: an undefined opcode in DECODE goes to HALT with retire=0. An extra output `illegal` (1 bit) is set and stays high until reset.
- Undefined: NOP behaviour as above and no `illegal` port.

Test Plan:
- Program 0201, 0401, 8650, F000 from reset, en=1 -> retire pulses at cycles 4, 8, 12, 14. halted=1 from cycle 15. R3=2 and pc=4 after halt.
- ADD instruction -> exact state sequence 0,1,2,4,0. rf_we high only in WB. alu_op=0, alu_src_imm=0 in EXEC.
- LW then SW -> LW takes 5 cycles with wb_sel=1 and rf_we in WB. SW asserts dmem_we in MEM only and never asserts rf_we.
- BEQ with zero=1 -> pc_we=1, pc_src=1 in EXEC. With zero=0 -> pc_we=0. Both return to FETCH after 3 cycles.
- Drop en to 0 for 3 cycles in the middle of EXEC -> state frozen at 2, all enables 0. Sequence resumes unchanged when en=1.
- Assert reset=0 asynchronously in WB -> state=0 immediately without waiting for a clock, and rf_we drops the same instant. Issue opcode 6 -> NOP path (or HALT with illegal=1 under CTRL_ILLEGAL_TRAP_EN).
